// File: rtl/npu_tile_controller.sv
// -----------------------------------------------------------------------------
// npu_tile_controller
//
// Tile sequencer for the NPU. It holds off PE-array compute until the data and
// weight loads from the AXI2NPU interface have completed. It then runs a
// fixed-length compute window, triggers the result-cache save, and waits for
// every result-cache channel to report its readout. This repeats for a
// programmable number of tiles. Load EOPs for the next tile are counted while
// the current tile computes or drains, so a prefetched tile can start one
// cycle after LOAD is entered.
//
// Optional feature (compile-time macro NPU_TILE_CTRL_WAIT_TIMEOUT_EN):
//   WAIT gives up after TIMEOUT_CYCLES cycles, forces DONE and sets the
//   sticky timeout_err_o flag. Without the macro, timeout_err_o is tied 0 and
//   WAIT waits indefinitely.
//
// Ports:
//   clk              clock
//   rst_n            asynchronous active-low reset
//   start_i          one-cycle job start, only honoured in IDLE
//   tile_num_i       number of tiles in the job, latched on an accepted start
//   wr_eop_data_i    data buffer write end-of-packet pulse
//   wr_eop_weight_i  weight buffer write end-of-packet pulse
//   rd_eop_i         per-channel result readout done pulses
//   clear_o          PE accumulator clear pulse (first EXEC cycle)
//   rd_sop_data_o    pe_control data read start pulse (first EXEC cycle)
//   rd_sop_weight_o  pe_control weight read start pulse (first EXEC cycle)
//   save_sop_o       result-cache save start pulse (SAVE cycle)
//   tile_done_o      one-cycle pulse when a tile's readout is complete
//   all_done_o       one-cycle pulse when the job is complete
//   busy_o           high in every state except IDLE
//   tile_idx_o       index of the current tile
//   ovf_o            sticky: an EOP arrived at a saturated counter
//   timeout_err_o    sticky: WAIT timed out (optional feature)
// -----------------------------------------------------------------------------
module npu_tile_controller #(
    parameter int unsigned DATA_EOPS      = 3,
    parameter int unsigned WEIGHT_EOPS    = 3,
    parameter int unsigned COMPUTE_CYCLES = 25,
    parameter int unsigned NUM_CH         = 8,
    parameter int unsigned TILE_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [TILE_W-1:0] tile_num_i,
    input  logic              wr_eop_data_i,
    input  logic              wr_eop_weight_i,
    input  logic [NUM_CH-1:0] rd_eop_i,
    output logic              clear_o,
    output logic              rd_sop_data_o,
    output logic              rd_sop_weight_o,
    output logic              save_sop_o,
    output logic              tile_done_o,
    output logic              all_done_o,
    output logic              busy_o,
    output logic [TILE_W-1:0] tile_idx_o,
    output logic              ovf_o,
    output logic              timeout_err_o
);

    localparam int unsigned DataCntW   = $clog2(DATA_EOPS + 1);
    localparam int unsigned WeightCntW = $clog2(WEIGHT_EOPS + 1);
    localparam int unsigned CycCntW    = $clog2(COMPUTE_CYCLES);

    localparam logic [DataCntW-1:0]   DataFull   = DataCntW'(DATA_EOPS);
    localparam logic [WeightCntW-1:0] WeightFull = WeightCntW'(WEIGHT_EOPS);
    localparam logic [CycCntW-1:0]    CycLast    = CycCntW'(COMPUTE_CYCLES - 1);

    typedef enum logic [5:0] {
        StIdle = 6'b000001,
        StLoad = 6'b000010,
        StExec = 6'b000100,
        StSave = 6'b001000,
        StWait = 6'b010000,
        StDone = 6'b100000
    } state_e;

    state_e              state_q, state_d;
    logic [TILE_W-1:0]   tile_num_q, tile_num_d;
    logic [TILE_W-1:0]   tile_idx_q, tile_idx_d;
    logic [DataCntW-1:0] dcnt_q, dcnt_d;
    logic [WeightCntW-1:0] wcnt_q, wcnt_d;
    logic [CycCntW-1:0]  cyc_q, cyc_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                ovf_q, ovf_d;
    logic                exec_sop_q, exec_sop_d;
    logic                save_sop_q, save_sop_d;
    logic                tile_done_q, tile_done_d;
    logic                all_done_q, all_done_d;
    logic                busy_q, busy_d;

    logic                data_full;
    logic                weight_full;
    logic [NUM_CH-1:0]   mask_next;

`ifdef NPU_TILE_CTRL_WAIT_TIMEOUT_EN
    localparam int unsigned TmoCntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TmoCntW-1:0] TmoLast = TmoCntW'(TIMEOUT_CYCLES - 1);

    logic [TmoCntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic               tmo_err_q, tmo_err_d;
`endif

    // Elaboration-constant parameter range checks (simulation only).
    always_comb begin
        assert (DATA_EOPS >= 1 && DATA_EOPS <= 15);
        assert (WEIGHT_EOPS >= 1 && WEIGHT_EOPS <= 15);
        assert (COMPUTE_CYCLES >= 2 && COMPUTE_CYCLES <= 1023);
        assert (NUM_CH >= 1 && TILE_W >= 1);
        assert (TIMEOUT_CYCLES >= 2);
    end

    assign data_full   = (dcnt_q == DataFull);
    assign weight_full = (wcnt_q == WeightFull);
    assign mask_next   = mask_q | rd_eop_i;

    always_comb begin
        state_d     = state_q;
        tile_num_d  = tile_num_q;
        tile_idx_d  = tile_idx_q;
        dcnt_d      = dcnt_q;
        wcnt_d      = wcnt_q;
        cyc_d       = cyc_q;
        mask_d      = mask_q;
        ovf_d       = ovf_q;
        exec_sop_d  = 1'b0;
        save_sop_d  = 1'b0;
        tile_done_d = 1'b0;
        all_done_d  = 1'b0;
`ifdef NPU_TILE_CTRL_WAIT_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;
`endif

        // Load EOPs are counted in every active state so the next tile can
        // prefetch; an EOP at a full counter is lost and flagged.
        if (state_q != StIdle) begin
            if (wr_eop_data_i) begin
                if (data_full) ovf_d = 1'b1;
                else           dcnt_d = dcnt_q + DataCntW'(1);
            end
            if (wr_eop_weight_i) begin
                if (weight_full) ovf_d = 1'b1;
                else             wcnt_d = wcnt_q + WeightCntW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (tile_num_i != '0) begin
                        state_d    = StLoad;
                        tile_num_d = tile_num_i;
                        tile_idx_d = '0;
                        dcnt_d     = '0;
                        wcnt_d     = '0;
                        ovf_d      = 1'b0;
`ifdef NPU_TILE_CTRL_WAIT_TIMEOUT_EN
                        tmo_err_d  = 1'b0;
`endif
                    end else begin
                        all_done_d = 1'b1;
                    end
                end
            end

            StLoad: begin
                if (data_full && weight_full) begin
                    state_d    = StExec;
                    exec_sop_d = 1'b1;
                    cyc_d      = '0;
                    // Counters restart for the next tile; an EOP on this edge
                    // already belongs to it and is not an overflow.
                    dcnt_d     = DataCntW'(wr_eop_data_i);
                    wcnt_d     = WeightCntW'(wr_eop_weight_i);
                    ovf_d      = ovf_q;
                end
            end

            StExec: begin
                if (cyc_q == CycLast) begin
                    state_d    = StSave;
                    save_sop_d = 1'b1;
                    cyc_d      = '0;
                    mask_d     = '0;
                end else begin
                    cyc_d = cyc_q + CycCntW'(1);
                end
            end

            StSave: begin
                // Readouts can complete as early as the save cycle itself.
                mask_d  = mask_next;
                state_d = StWait;
`ifdef NPU_TILE_CTRL_WAIT_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            StWait: begin
                mask_d = mask_next;
                if (&mask_next) begin
                    state_d     = StDone;
                    tile_done_d = 1'b1;
                end
`ifdef NPU_TILE_CTRL_WAIT_TIMEOUT_EN
                else if (tmo_cnt_q == TmoLast) begin
                    state_d     = StDone;
                    tile_done_d = 1'b1;
                    tmo_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoCntW'(1);
                end
`endif
            end

            StDone: begin
                if (tile_idx_q == tile_num_q - TILE_W'(1)) begin
                    state_d    = StIdle;
                    all_done_d = 1'b1;
                end else begin
                    state_d    = StLoad;
                    tile_idx_d = tile_idx_q + TILE_W'(1);
                end
            end

            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tile_num_q  <= '0;
            tile_idx_q  <= '0;
            dcnt_q      <= '0;
            wcnt_q      <= '0;
            cyc_q       <= '0;
            mask_q      <= '0;
            ovf_q       <= 1'b0;
            exec_sop_q  <= 1'b0;
            save_sop_q  <= 1'b0;
            tile_done_q <= 1'b0;
            all_done_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef NPU_TILE_CTRL_WAIT_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tile_num_q  <= tile_num_d;
            tile_idx_q  <= tile_idx_d;
            dcnt_q      <= dcnt_d;
            wcnt_q      <= wcnt_d;
            cyc_q       <= cyc_d;
            mask_q      <= mask_d;
            ovf_q       <= ovf_d;
            exec_sop_q  <= exec_sop_d;
            save_sop_q  <= save_sop_d;
            tile_done_q <= tile_done_d;
            all_done_q  <= all_done_d;
            busy_q      <= busy_d;
`ifdef NPU_TILE_CTRL_WAIT_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
`endif
        end
    end

    assign clear_o         = exec_sop_q;
    assign rd_sop_data_o   = exec_sop_q;
    assign rd_sop_weight_o = exec_sop_q;
    assign save_sop_o      = save_sop_q;
    assign tile_done_o     = tile_done_q;
    assign all_done_o      = all_done_q;
    assign busy_o          = busy_q;
    assign tile_idx_o      = tile_idx_q;
    assign ovf_o           = ovf_q;

`ifdef NPU_TILE_CTRL_WAIT_TIMEOUT_EN
    assign timeout_err_o = tmo_err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_npu_tile_controller.sv
// -----------------------------------------------------------------------------
// tb_npu_tile_controller
//
// Directed bench for npu_tile_controller with default parameters. Stimulus
// pushes hand-computed output events (pulse pattern, cycle number, tile index,
// flags) into a queue; a monitor on the falling clock edge pops one entry for
// every cycle in which any output pulse is high and compares.
// -----------------------------------------------------------------------------
module tb_npu_tile_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tile_num = 8'd0;
    logic       wr_eop_data = 1'b0;
    logic       wr_eop_weight = 1'b0;
    logic [7:0] rd_eop = 8'h00;

    logic       clear, rd_sop_data, rd_sop_weight, save_sop;
    logic       tile_done, all_done, busy, ovf, timeout_err;
    logic [7:0] tile_idx;

    npu_tile_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .tile_num_i      (tile_num),
        .wr_eop_data_i   (wr_eop_data),
        .wr_eop_weight_i (wr_eop_weight),
        .rd_eop_i        (rd_eop),
        .clear_o         (clear),
        .rd_sop_data_o   (rd_sop_data),
        .rd_sop_weight_o (rd_sop_weight),
        .save_sop_o      (save_sop),
        .tile_done_o     (tile_done),
        .all_done_o      (all_done),
        .busy_o          (busy),
        .tile_idx_o      (tile_idx),
        .ovf_o           (ovf),
        .timeout_err_o   (timeout_err)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval that follows the n-th rising edge.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse pattern: {clear, rd_sop_data, rd_sop_weight, save_sop, tile_done, all_done}
    localparam logic [5:0] PExec = 6'b111000;
    localparam logic [5:0] PSave = 6'b000100;
    localparam logic [5:0] PTile = 6'b000010;
    localparam logic [5:0] PAll  = 6'b000001;

    typedef struct packed {
        logic [15:0] tag;
        logic [5:0]  pulses;
        logic [31:0] cycle;
        logic [7:0]  idx;
        logic        ovf;
        logic        busy;
        logic        terr;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned n_tag = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic void exp_ev(input logic [5:0] p, input int unsigned c,
                                   input logic [7:0] idx, input logic o,
                                   input logic b, input logic t);
        ev_t e;
        e.tag    = 16'(n_tag);
        e.pulses = p;
        e.cycle  = c;
        e.idx    = idx;
        e.ovf    = o;
        e.busy   = b;
        e.terr   = t;
        n_tag++;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [5:0] p;
        ev_t        e;
        p = {clear, rd_sop_data, rd_sop_weight, save_sop, tile_done, all_done};
        if (rst_n && p != 6'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: pulses=%b cyc=%0d idx=%0d", p, cyc, tile_idx);
            end else begin
                e = exp_q.pop_front();
                if (p !== e.pulses || cyc != e.cycle || tile_idx !== e.idx ||
                    ovf !== e.ovf || busy !== e.busy || timeout_err !== e.terr) begin
                    errors++;
                    $display({"FAIL event_%0d: got pulses=%b cyc=%0d idx=%0d ovf=%b busy=%b ",
                              "terr=%b; expected pulses=%b cyc=%0d idx=%0d ovf=%b busy=%b ",
                              "terr=%b"},
                             e.tag, p, cyc, tile_idx, ovf, busy, timeout_err,
                             e.pulses, e.cycle, e.idx, e.ovf, e.busy, e.terr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) tick();
    endtask

    // Drive one cycle of load/readout pulses in cycle c.
    task automatic drive_at(input int unsigned c, input logic d, input logic w,
                            input logic [7:0] rd);
        wait_until(c);
        wr_eop_data   = d;
        wr_eop_weight = w;
        rd_eop        = rd;
        tick();
        wr_eop_data   = 1'b0;
        wr_eop_weight = 1'b0;
        rd_eop        = 8'h00;
    endtask

    task automatic do_start(input logic [7:0] n, output int unsigned sc);
        sc       = cyc;
        start    = 1'b1;
        tile_num = n;
        tick();
        start    = 1'b0;
    endtask

    logic [7:0] rd_seq [12];

    initial begin
        int unsigned s;
        int unsigned t;
        ev_t         e;

        rd_seq = '{8'h80, 8'h01, 8'h02, 8'h02, 8'h04, 8'h08,
                   8'h08, 8'h10, 8'h20, 8'h40, 8'h00, 8'h80};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              32'({clear, rd_sop_data, rd_sop_weight, save_sop, tile_done, all_done,
                   busy, ovf, timeout_err, tile_idx}), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single tile, EOPs in lockstep, stray start during EXEC ignored
        do_start(8'd1, s);
        exp_ev(PExec, s + 5,  8'd0, 1'b0, 1'b1, 1'b0);
        exp_ev(PSave, s + 30, 8'd0, 1'b0, 1'b1, 1'b0);
        exp_ev(PTile, s + 32, 8'd0, 1'b0, 1'b1, 1'b0);
        exp_ev(PAll,  s + 33, 8'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) drive_at(s + i, 1'b1, 1'b1, 8'h00);
        wait_until(s + 10);
        start    = 1'b1;
        tile_num = 8'd5;
        tick();
        start    = 1'b0;
        drive_at(s + 31, 1'b0, 1'b0, 8'hFF);
        wait_until(s + 36);

        // Interleaved EOPs; readout bits one at a time with duplicates
        do_start(8'd1, s);
        exp_ev(PExec, s + 8,  8'd0, 1'b0, 1'b1, 1'b0);
        exp_ev(PSave, s + 33, 8'd0, 1'b0, 1'b1, 1'b0);
        exp_ev(PTile, s + 44, 8'd0, 1'b0, 1'b1, 1'b0);
        exp_ev(PAll,  s + 45, 8'd0, 1'b0, 1'b0, 1'b0);
        drive_at(s + 1, 1'b0, 1'b1, 8'h00);
        drive_at(s + 2, 1'b1, 1'b0, 8'h00);
        drive_at(s + 3, 1'b0, 1'b1, 8'h00);
        drive_at(s + 4, 1'b1, 1'b0, 8'h00);
        drive_at(s + 6, 1'b1, 1'b1, 8'h00);
        // Bit 7 in the last EXEC cycle must be discarded; bit 0 only in SAVE.
        for (int i = 0; i < 12; i++) drive_at(s + 32 + i, 1'b0, 1'b0, rd_seq[i]);
        wait_until(s + 48);

        // Three tiles with next-tile EOPs prefetched during EXEC
        do_start(8'd3, s);
        exp_ev(PExec, s + 5,  8'd0, 1'b0, 1'b1, 1'b0);
        exp_ev(PSave, s + 30, 8'd0, 1'b0, 1'b1, 1'b0);
        exp_ev(PTile, s + 32, 8'd0, 1'b0, 1'b1, 1'b0);
        exp_ev(PExec, s + 34, 8'd1, 1'b0, 1'b1, 1'b0);
        exp_ev(PSave, s + 59, 8'd1, 1'b0, 1'b1, 1'b0);
        exp_ev(PTile, s + 61, 8'd1, 1'b0, 1'b1, 1'b0);
        exp_ev(PExec, s + 63, 8'd2, 1'b0, 1'b1, 1'b0);
        exp_ev(PSave, s + 88, 8'd2, 1'b0, 1'b1, 1'b0);
        exp_ev(PTile, s + 90, 8'd2, 1'b0, 1'b1, 1'b0);
        exp_ev(PAll,  s + 91, 8'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) drive_at(s + i, 1'b1, 1'b1, 8'h00);
        drive_at(s + 4, 1'b1, 1'b0, 8'h00);   // lands on the LOAD exit edge
        drive_at(s + 10, 1'b1, 1'b1, 8'h00);
        drive_at(s + 11, 1'b1, 1'b1, 8'h00);
        drive_at(s + 12, 1'b0, 1'b1, 8'h00);
        drive_at(s + 31, 1'b0, 1'b0, 8'hFF);
        for (int i = 40; i <= 42; i++) drive_at(s + i, 1'b1, 1'b1, 8'h00);
        drive_at(s + 60, 1'b0, 1'b0, 8'hFF);
        drive_at(s + 89, 1'b0, 1'b0, 8'hFF);
        wait_until(s + 94);

        // Overflow: 4th data EOP while the data counter is full
        do_start(8'd1, s);
        exp_ev(PExec, s + 8,  8'd0, 1'b1, 1'b1, 1'b0);
        exp_ev(PSave, s + 33, 8'd0, 1'b1, 1'b1, 1'b0);
        exp_ev(PTile, s + 35, 8'd0, 1'b1, 1'b1, 1'b0);
        exp_ev(PAll,  s + 36, 8'd0, 1'b1, 1'b0, 1'b0);
        drive_at(s + 1, 1'b1, 1'b1, 8'h00);
        drive_at(s + 2, 1'b1, 1'b1, 8'h00);
        drive_at(s + 3, 1'b1, 1'b0, 8'h00);
        drive_at(s + 4, 1'b1, 1'b0, 8'h00);
        drive_at(s + 6, 1'b0, 1'b1, 8'h00);
        drive_at(s + 34, 1'b0, 1'b0, 8'hFF);
        wait_until(s + 40);
        check("ovf_sticky_in_idle", 32'(ovf), 32'd1);

        // Next start clears ovf; overflow again in EXEC, then reset mid-EXEC
        do_start(8'd1, t);
        exp_ev(PExec, t + 5, 8'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) drive_at(t + i, 1'b1, 1'b1, 8'h00);
        for (int i = 6; i <= 9; i++) drive_at(t + i, 1'b1, 1'b0, 8'h00);
        wait_until(t + 11);
        check("ovf_in_exec", 32'(ovf), 32'd1);
        check("busy_in_exec", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({clear, rd_sop_data, rd_sop_weight, save_sop, tile_done, all_done,
                   busy, ovf, timeout_err, tile_idx}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("idle_after_reset", 32'(busy), 32'd0);

        // Zero-tile job: all_done only, never busy
        do_start(8'd0, s);
        exp_ev(PAll, s + 1, 8'd0, 1'b0, 1'b0, 1'b0);
        check("zero_tiles_busy_c1", 32'(busy), 32'd0);
        tick();
        check("zero_tiles_busy_c2", 32'(busy), 32'd0);
        repeat (3) tick();

        // WAIT with channel 0 never reporting
        do_start(8'd1, s);
        exp_ev(PExec, s + 5,  8'd0, 1'b0, 1'b1, 1'b0);
        exp_ev(PSave, s + 30, 8'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) drive_at(s + i, 1'b1, 1'b1, 8'h00);
        wait_until(s + 30);
        rd_eop = 8'hFE;
`ifdef NPU_TILE_CTRL_WAIT_TIMEOUT_EN
        exp_ev(PTile, s + 1055, 8'd0, 1'b0, 1'b1, 1'b1);
        exp_ev(PAll,  s + 1056, 8'd0, 1'b0, 1'b0, 1'b1);
        wait_until(s + 1060);
        rd_eop = 8'h00;
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);
`else
        wait_until(s + 2031);
        check("wait_still_busy", 32'(busy), 32'd1);
        check("no_timeout_err", 32'(timeout_err), 32'd0);
        exp_ev(PTile, s + 2032, 8'd0, 1'b0, 1'b1, 1'b0);
        exp_ev(PAll,  s + 2033, 8'd0, 1'b0, 1'b0, 1'b0);
        rd_eop = 8'h01;
        tick();
        rd_eop = 8'h00;
        wait_until(s + 2036);
`endif

        repeat (4) tick();
        check("pending_events", 32'(exp_q.size()), 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("  missing event_%0d pulses=%b cyc=%0d", e.tag, e.pulses, e.cycle);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
